// File: rtl/seq_jkff_bank_arbiter_pkg.sv
// Shared JK flip-flop definitions: op encodings and the per-bit next-state function
// used by every JK-style register block.
package seq_jkff_bank_arbiter_pkg;

    localparam logic [1:0] JK_HOLD = 2'b00;
    localparam logic [1:0] JK_CLR  = 2'b01;
    localparam logic [1:0] JK_SET  = 2'b10;
    localparam logic [1:0] JK_TOG  = 2'b11;

    function automatic logic jk_next(input logic q, input logic j, input logic k);
        logic r;
        case ({j, k})
            JK_HOLD: r = q;
            JK_CLR:  r = 1'b0;
            JK_SET:  r = 1'b1;
            JK_TOG:  r = ~q;
            default: r = q;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/seq_jkff_bank_arbiter_rr_arb_pick.sv
// Combinational round-robin pick: first requester with req set, scanning upward
// from ptr and wrapping modulo NREQ.
module rr_arb_pick
    import seq_jkff_bank_arbiter_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int PW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic            valid,
    output logic [PW-1:0]   win
);

    logic [PW-1:0] idx_s;

    // Scan every rotation offset and keep only the first hit.
    always_comb begin
        valid = 1'b0;
        win   = '0;
        idx_s = '0;
        for (int i = 0; i < NREQ; i++) begin
            idx_s = PW'((int'(ptr) + i) % NREQ);
            if (!valid && req[idx_s]) begin
                valid = 1'b1;
                win   = idx_s;
            end else begin
                win = win;
            end
        end
    end

endmodule

// File: rtl/seq_jkff_bank_arbiter.sv
// Shared JK flip-flop bank with round-robin arbitration among NREQ requesters and
// a bounded lock that lets the current owner keep the bank for back-to-back commands.
module seq_jkff_bank_arbiter
    import seq_jkff_bank_arbiter_pkg::*;
#(
    parameter int NREQ     = 4,
    parameter int NBITS    = 8,
    parameter int MAX_LOCK = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ-1:0]       lock,
    input  logic [NREQ*NBITS-1:0] j,
    input  logic [NREQ*NBITS-1:0] k,
    output logic [NREQ-1:0]       gnt,
    output logic [NBITS-1:0]      q
);

    localparam int PW = $clog2(NREQ);
    localparam int RW = $clog2(MAX_LOCK + 1);

    logic [NBITS-1:0] q_r, q_nx_s;
    logic [NREQ-1:0]  gnt_r, gnt_nx_s;
    logic [PW-1:0]    ptr_r, ptr_nx_s, owner_r, owner_nx_s;
    logic [RW-1:0]    run_len_r, run_len_nx_s;
    logic             pick_valid_s, locked_s, have_win_s;
    logic [PW-1:0]    pick_win_s, win_s;
    logic [NBITS-1:0] j_arr_s [NREQ];
    logic [NBITS-1:0] k_arr_s [NREQ];

    for (genvar r = 0; r < NREQ; r++) begin : g_unpack
        assign j_arr_s[r] = j[r*NBITS +: NBITS];
        assign k_arr_s[r] = k[r*NBITS +: NBITS];
    end

    rr_arb_pick #(.NREQ(NREQ), .PW(PW)) u_pick (
        .req   (req),
        .ptr   (ptr_r),
        .valid (pick_valid_s),
        .win   (pick_win_s)
    );

    // Winner selection with lock override, JK update and arbitration bookkeeping.
    always_comb begin
        q_nx_s       = q_r;
        gnt_nx_s     = '0;
        owner_nx_s   = owner_r;
        run_len_nx_s = '0;
        ptr_nx_s     = ptr_r;
        win_s        = '0;
        have_win_s   = 1'b0;

        // Lock only counts for the registered owner that is still requesting.
        if ((gnt_r != '0) && req[owner_r] && lock[owner_r] && (run_len_r < RW'(MAX_LOCK))) begin
            locked_s = 1'b1;
        end else begin
            locked_s = 1'b0;
        end

        if (locked_s) begin
            win_s      = owner_r;
            have_win_s = 1'b1;
        end else if (pick_valid_s) begin
            win_s      = pick_win_s;
            have_win_s = 1'b1;
        end else begin
            have_win_s = 1'b0;
        end

        if (have_win_s) begin
            for (int i = 0; i < NBITS; i++) begin
                q_nx_s[i] = jk_next(q_r[i], j_arr_s[win_s][i], k_arr_s[win_s][i]);
            end
            gnt_nx_s[win_s] = 1'b1;
            owner_nx_s      = win_s;
            if (locked_s) begin
                run_len_nx_s = run_len_r + RW'(1);
            end else begin
                run_len_nx_s = RW'(1);
                ptr_nx_s     = (win_s == PW'(NREQ - 1)) ? PW'(0) : win_s + PW'(1);
            end
        end else begin
            run_len_nx_s = '0;
        end
    end

    // State registers; reset discards any lock run in progress.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q_r       <= '0;
            gnt_r     <= '0;
            ptr_r     <= '0;
            owner_r   <= '0;
            run_len_r <= '0;
        end else begin
            q_r       <= q_nx_s;
            gnt_r     <= gnt_nx_s;
            ptr_r     <= ptr_nx_s;
            owner_r   <= owner_nx_s;
            run_len_r <= run_len_nx_s;
        end
    end

    assign q   = q_r;
    assign gnt = gnt_r;

endmodule

// File: tb/tb_seq_jkff_bank_arbiter.sv
// Directed self-checking bench for seq_jkff_bank_arbiter (NREQ=4, NBITS=8, MAX_LOCK=4).
module tb_seq_jkff_bank_arbiter;

    logic        clk;
    logic        reset;
    logic [3:0]  req;
    logic [3:0]  lock;
    logic [31:0] j;
    logic [31:0] k;
    logic [3:0]  gnt;
    logic [7:0]  q;

    int chk_cnt;
    int pass_cnt;

    seq_jkff_bank_arbiter #(.NREQ(4), .NBITS(8), .MAX_LOCK(4)) dut (
        .clk   (clk),
        .reset (reset),
        .req   (req),
        .lock  (lock),
        .j     (j),
        .k     (k),
        .gnt   (gnt),
        .q     (q)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b0;
        req   = 4'b0000;
        lock  = 4'b0000;
        j     = 32'h0;
        k     = 32'h0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        req   = 4'b0000;
        lock  = 4'b0000;
        j     = 32'h0;
        k     = 32'h0;
        #1 reset = 1'b0;
        #2;
        chk_cnt++;
        if (q !== 8'h00) $display("FAIL reset_q_async got=%h exp=00", q);
        else pass_cnt++;
        chk_cnt++;
        if (gnt !== 4'b0000) $display("FAIL reset_gnt_async got=%b exp=0000", gnt);
        else pass_cnt++;
        @(negedge clk);
        reset = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            chk_cnt++;
            if (q !== 8'h00) $display("FAIL reset_idle_q cyc=%0d got=%h exp=00", c, q);
            else pass_cnt++;
            chk_cnt++;
            if (gnt !== 4'b0000) $display("FAIL reset_idle_gnt cyc=%0d got=%b exp=0000", c, gnt);
            else pass_cnt++;
        end
    endtask

    task automatic test_single();
        logic [7:0] jv [4];
        logic [7:0] kv [4];
        logic [3:0] rv [4];
        logic [7:0] qe [4];
        logic [3:0] ge [4];
        jv = '{8'hFF, 8'h00, 8'hFF, 8'hFF};
        kv = '{8'h00, 8'h0F, 8'hFF, 8'hFF};
        rv = '{4'b0001, 4'b0001, 4'b0001, 4'b0000};
        qe = '{8'hFF, 8'hF0, 8'h0F, 8'h0F};
        ge = '{4'b0001, 4'b0001, 4'b0001, 4'b0000};
        apply_reset();
        for (int c = 0; c < 4; c++) begin
            req      = rv[c];
            j[7:0]   = jv[c];
            k[7:0]   = kv[c];
            step();
            chk_cnt++;
            if (q !== qe[c]) $display("FAIL single_q step=%0d got=%h exp=%h", c, q, qe[c]);
            else pass_cnt++;
            chk_cnt++;
            if (gnt !== ge[c]) $display("FAIL single_gnt step=%0d got=%b exp=%b", c, gnt, ge[c]);
            else pass_cnt++;
        end
    endtask

    task automatic test_round_robin();
        logic [3:0] ge [5];
        ge = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        apply_reset();
        req = 4'b1111;
        for (int c = 0; c < 5; c++) begin
            step();
            chk_cnt++;
            if (gnt !== ge[c]) $display("FAIL rr_gnt step=%0d got=%b exp=%b", c, gnt, ge[c]);
            else pass_cnt++;
        end
    endtask

    task automatic test_skip_wrap();
        logic [3:0] ge [4];
        ge = '{4'b0010, 4'b1000, 4'b0010, 4'b1000};
        apply_reset();
        req = 4'b1010;
        for (int c = 0; c < 4; c++) begin
            step();
            chk_cnt++;
            if (gnt !== ge[c]) $display("FAIL skip_gnt step=%0d got=%b exp=%b", c, gnt, ge[c]);
            else pass_cnt++;
        end
    endtask

    task automatic test_lock_cap();
        logic [3:0] ge [9];
        logic [7:0] qe [9];
        ge = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0010,
               4'b0001, 4'b0001, 4'b0001, 4'b0001};
        qe = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h01,
               8'h01, 8'h01, 8'h01, 8'h01};
        apply_reset();
        req     = 4'b0011;
        lock    = 4'b0001;
        j[15:8] = 8'h01;
        for (int c = 0; c < 9; c++) begin
            step();
            chk_cnt++;
            if (gnt !== ge[c]) $display("FAIL lock_gnt step=%0d got=%b exp=%b", c, gnt, ge[c]);
            else pass_cnt++;
            chk_cnt++;
            if (q !== qe[c]) $display("FAIL lock_q step=%0d got=%h exp=%h", c, q, qe[c]);
            else pass_cnt++;
        end
    endtask

    task automatic test_async_reset();
        apply_reset();
        req      = 4'b0100;
        j[23:16] = 8'hA5;
        step();
        chk_cnt++;
        if (gnt !== 4'b0100) $display("FAIL async_pre_gnt got=%b exp=0100", gnt);
        else pass_cnt++;
        chk_cnt++;
        if (q !== 8'hA5) $display("FAIL async_pre_q got=%h exp=a5", q);
        else pass_cnt++;
        #2 reset = 1'b0;
        #1;
        chk_cnt++;
        if (q !== 8'h00) $display("FAIL async_mid_q got=%h exp=00", q);
        else pass_cnt++;
        chk_cnt++;
        if (gnt !== 4'b0000) $display("FAIL async_mid_gnt got=%b exp=0000", gnt);
        else pass_cnt++;
        @(negedge clk);
        reset = 1'b1;
        req   = 4'b1100;
        j     = 32'h0;
        step();
        chk_cnt++;
        if (gnt !== 4'b0100) $display("FAIL async_post_gnt got=%b exp=0100", gnt);
        else pass_cnt++;
        step();
        chk_cnt++;
        if (gnt !== 4'b1000) $display("FAIL async_post_gnt2 got=%b exp=1000", gnt);
        else pass_cnt++;
        chk_cnt++;
        if (q !== 8'h00) $display("FAIL async_post_q got=%h exp=00", q);
        else pass_cnt++;
    endtask

    initial begin
        chk_cnt  = 0;
        pass_cnt = 0;
        test_reset();
        test_single();
        test_round_robin();
        test_skip_wrap();
        test_lock_cap();
        test_async_reset();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/seq_jkff_bank_arbiter.md
Name: seq_jkff_bank_arbiter

Overview:
- Shares one bank of NBITS JK flip-flops among NREQ requesters.
- Each cycle, a round-robin arbiter picks one requester. The bank then applies that requester's J/K vectors at the clock edge.
- A lock input lets the current owner keep the bank for back-to-back commands, up to MAX_LOCK cycles.
- Sits between multiple control agents and a shared JK-style status/flag register.

Parameters:
- NREQ, 4, number of requesters (>=2).
- NBITS, 8, width of the JK flip-flop bank.
- MAX_LOCK, 4, maximum consecutive grants one owner may hold via lock (>=1).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset. Low clears all state immediately; release is synchronous to clk.
- req  input  NREQ  per-requester request; bit r asserts requester r.
- lock  input  NREQ  per-requester lock; meaningful only for the current owner while its req is high.
- j  input  NREQ*NBITS  J vectors; requester r uses bits [r*NBITS +: NBITS].
- k  input  NREQ*NBITS  K vectors; same slicing as j.
- gnt  output  NREQ  registered one-hot: the requester whose command was applied at the last edge; 0 if none.
- q  output  NBITS  JK bank state.

Behaviour:
- Reset (reset=0, any time, no clock needed): q=0, gnt=0, ptr=0, run_len=0. Reset mid-operation discards any in-progress lock.
- Internal state:
  - ptr (clog2(NREQ) bits): highest-priority index.
  - owner: index of the set bit in gnt.
  - run_len (clog2(MAX_LOCK+1) bits).
- Winner selection (combinational, evaluated each cycle):
  - LOCKED case: gnt!=0, req[owner]=1, lock[owner]=1 and run_len<MAX_LOCK → winner=owner.
  - Otherwise, winner is the first r with req[r]=1, scanning ptr, ptr+1, ... modulo NREQ.
  - If req==0, there is no winner.
- At the rising edge with a winner w:
  - For each bit i, apply JK to q[i] using j[w][i], k[w][i]: 00 hold, 01 clear, 10 set, 11 toggle.
  - gnt <= onehot(w).
  - In the LOCKED case: run_len <= run_len+1, ptr unchanged.
  - Otherwise: run_len <= 1, ptr <= (w+1) mod NREQ.
- At the rising edge with no winner: q holds, gnt <= 0, run_len <= 0, ptr holds.
- Latency: a command presented in cycle n is visible on q and gnt after edge n (one edge).
- Conceptual states:
  - IDLE (gnt=0).
  - OWNED (gnt!=0, run_len<MAX_LOCK).
  - EXHAUSTED (run_len=MAX_LOCK): lock is ignored and a normal round-robin pick occurs. The same requester may still win if it is the next requester with req set in rotation.
- Boundary rules:
  - lock without req is ignored.
  - lock from a non-owner is ignored.
  - Owner dropping req releases ownership immediately.
  - ptr wraps NREQ-1 → 0.
  - Inputs are sampled only at the edge; no combinational path from inputs to outputs.

Decomposition:
- Shared package: the JK op encoding constants (JK_HOLD=2'b00, JK_CLR=2'b01, JK_SET=2'b10, JK_TOG=2'b11) and a function jk_next(q,j,k) shared with the existing JK flip-flop blocks.
- One sub-module: rr_arb_pick. Combinational; inputs req and ptr, outputs valid and the winner index.
- Lock override, counters and the JK bank stay in the top module.

Test Plan (NREQ=4, NBITS=8, MAX_LOCK=4):
- Reset: hold reset=0 → q=8'h00, gnt=4'b0000 without a clock edge. Release with req=0 for 3 cycles → q=8'h00, gnt=4'b0000.
- Single requester 0 (req=4'b0001), one command per edge:
  - j0=FF, k0=00 → q=FF, gnt=0001.
  - then j0=00, k0=0F → q=F0.
  - then j0=FF, k0=FF → q=0F.
  - then req=0 → q=0F held, gnt=0000.
- Round-robin: req=4'b1111, lock=0, held for 5 edges → gnt sequence 0001, 0010, 0100, 1000, 0001.
- Skip and wrap: from reset, req=4'b1010 → gnt sequence 0010, 1000, 0010, 1000.
- Lock cap: req=4'b0011, lock=4'b0001 → gnt=0001 for 4 edges, then 0010, then 0001 (new lock run of 4). Requester 1 applying j1=01, k1=00 during its grant → q bit 0 set.
- Async reset mid-operation: while gnt=0100 and q=A5, pull reset low between edges → q=00, gnt=0000 immediately. After release with req=4'b1100, first gnt=0100 (ptr back to 0).
